// File: rtl/main_cu_pkg.sv
// Shared definitions for the matrix-multiplication main control unit.
// Holds status-word bit positions, config-word field positions, the FSM
// state encoding and a small helper for building status write-back words.
package main_cu_pkg;

  localparam int unsigned STATUS_W         = 32;
  localparam int unsigned STATUS_START_BIT = 31;
  localparam int unsigned STATUS_BUSY_BIT  = 30;
  localparam int unsigned STATUS_DONE_BIT  = 29;
  localparam int unsigned STATUS_ERROR_BIT = 28;

  // Config word: [31:24] A rows, [23:16] A cols, [15:8] B rows, [7:0] B cols
  localparam int unsigned CFG_FIELD_W    = 8;
  localparam int unsigned CFG_A_ROWS_LSB = 24;
  localparam int unsigned CFG_A_COLS_LSB = 16;
  localparam int unsigned CFG_B_ROWS_LSB = 8;
  localparam int unsigned CFG_B_COLS_LSB = 0;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START       = 3'd1,
    DISPATCH    = 3'd2,
    WAIT_ACK    = 3'd3,
    WAIT_REL    = 3'd4,
    WAIT_RESULT = 3'd5,
    DONE        = 3'd6,
    ERROR       = 3'd7
  } state_t;

  // Single-bit mask at a status bit position
  function automatic logic [STATUS_W-1:0] status_bit(input int unsigned pos);
    return STATUS_W'(1) << pos;
  endfunction

  // Current status with clr bits cleared and set bits set
  function automatic logic [STATUS_W-1:0] status_with(
    input logic [STATUS_W-1:0] cur,
    input logic [STATUS_W-1:0] clr,
    input logic [STATUS_W-1:0] set
  );
    return (cur & ~clr) | set;
  endfunction

endpackage

// File: rtl/main_cu_index_gen.sv
// Block index generator for main_cu.
// Walks the C-matrix block grid row-major (column fastest) and reports
// whether any block is still waiting to be dispatched.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load         latch rows/cols and restart at (0,0)
//   rows, cols   grid dimensions in blocks
//   advance      step to the next block
//   row, col     current block index
//   remain       at least one block not yet dispatched
module main_cu_index_gen
  import main_cu_pkg::*;
#(
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IDX_W-1:0] rows,
  input  logic [IDX_W-1:0] cols,
  input  logic             advance,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             remain
);

  logic [IDX_W-1:0] rows_q;
  logic [IDX_W-1:0] cols_q;
  logic             finished_q;

  // Counters and completion flag; an empty grid is finished at load time
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q     <= '0;
      cols_q     <= '0;
      row        <= '0;
      col        <= '0;
      finished_q <= 1'b1;
    end else if (load) begin
      rows_q     <= rows;
      cols_q     <= cols;
      row        <= '0;
      col        <= '0;
      finished_q <= (rows == '0) || (cols == '0);
    end else if (advance && !finished_q) begin
      if (col == cols_q - IDX_W'(1)) begin
        col <= '0;
        row <= row + IDX_W'(1);
        if (row == rows_q - IDX_W'(1)) begin
          finished_q <= 1'b1;
        end
      end else begin
        col <= col + IDX_W'(1);
      end
    end
  end

  assign remain = ~finished_q;

endmodule

// File: rtl/main_cu.sv
// Main control unit of the matrix-multiplication coprocessor.
// On a start request it latches the block grid from the config word, hands
// (row, col) block indexes to up to NUM_PU PUs per batch with a four-phase
// handshake, waits for each batch result and writes busy/done/error status.
// Optional feature macro: MAIN_CU_DIM_CHECK_EN (dimension check on start).
// Ports:
//   i_Clock, i_Reset        clock, synchronous active-high reset
//   i_Config                grid dimensions (A rows/cols, B rows/cols)
//   i_Status                current status word (start/busy/done/error)
//   i_Indexes_Received      PU acknowledge of the current index
//   i_Result_Ready          batch complete; rising edge consumed
//   o_Status                status word to write back
//   o_Write_Status_Enable   one-cycle write strobe for o_Status
//   o_Indexes_Ready         one-hot slot valid
//   o_Row_Index, o_Column_Index  block being dispatched
module main_cu
  import main_cu_pkg::*;
#(
  parameter int unsigned NUM_PU = 4,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic [31:0]       i_Config,
  input  logic [31:0]       i_Status,
  input  logic              i_Indexes_Received,
  input  logic              i_Result_Ready,
  output logic [31:0]       o_Status,
  output logic              o_Write_Status_Enable,
  output logic [NUM_PU-1:0] o_Indexes_Ready,
  output logic [IDX_W-1:0]  o_Row_Index,
  output logic [IDX_W-1:0]  o_Column_Index
);

  localparam int unsigned SLOT_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

  state_t              state;
  state_t              state_n;
  logic [SLOT_W-1:0]   slot;
  logic [SLOT_W-1:0]   slot_n;
  logic                result_q;
  logic                result_rise;
  logic                start_req;
  logic                dims_bad;

  logic [31:0]         status_n;
  logic                we_n;
  logic [NUM_PU-1:0]   ready_n;
  logic [IDX_W-1:0]    row_n;
  logic [IDX_W-1:0]    col_n;

  logic                gen_load;
  logic                gen_advance;
  logic                gen_remain;
  logic [IDX_W-1:0]    gen_row;
  logic [IDX_W-1:0]    gen_col;
  logic [IDX_W-1:0]    cfg_rows;
  logic [IDX_W-1:0]    cfg_cols;

  assign cfg_rows    = IDX_W'(i_Config[CFG_A_ROWS_LSB +: CFG_FIELD_W]);
  assign cfg_cols    = IDX_W'(i_Config[CFG_B_COLS_LSB +: CFG_FIELD_W]);
  assign start_req   = i_Status[STATUS_START_BIT] & ~i_Status[STATUS_BUSY_BIT];
  assign result_rise = i_Result_Ready & ~result_q;

`ifdef MAIN_CU_DIM_CHECK_EN
  // Inner dimensions must agree and the product grid must be non-empty
  assign dims_bad = (i_Config[CFG_A_COLS_LSB +: CFG_FIELD_W] !=
                     i_Config[CFG_B_ROWS_LSB +: CFG_FIELD_W]) ||
                    (cfg_rows == '0) || (cfg_cols == '0);
`else
  logic unused_cfg;
  assign dims_bad   = 1'b0;
  assign unused_cfg = ^i_Config[CFG_B_ROWS_LSB +: 2*CFG_FIELD_W];
`endif

  main_cu_index_gen #(
    .IDX_W(IDX_W)
  ) u_index_gen (
    .clk    (i_Clock),
    .rst    (i_Reset),
    .load   (gen_load),
    .rows   (cfg_rows),
    .cols   (cfg_cols),
    .advance(gen_advance),
    .row    (gen_row),
    .col    (gen_col),
    .remain (gen_remain)
  );

  // State, slot, result edge detector and registered outputs
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state                 <= IDLE;
      slot                  <= '0;
      result_q              <= 1'b0;
      o_Status              <= '0;
      o_Write_Status_Enable <= 1'b0;
      o_Indexes_Ready       <= '0;
      o_Row_Index           <= '0;
      o_Column_Index        <= '0;
    end else begin
      state                 <= state_n;
      slot                  <= slot_n;
      result_q              <= i_Result_Ready;
      o_Status              <= status_n;
      o_Write_Status_Enable <= we_n;
      o_Indexes_Ready       <= ready_n;
      o_Row_Index           <= row_n;
      o_Column_Index        <= col_n;
    end
  end

  // Next state and next output values; outputs hold unless a state changes them
  always_comb begin
    state_n     = state;
    slot_n      = slot;
    status_n    = o_Status;
    we_n        = 1'b0;
    ready_n     = o_Indexes_Ready;
    row_n       = o_Row_Index;
    col_n       = o_Column_Index;
    gen_load    = 1'b0;
    gen_advance = 1'b0;

    case (state)
      IDLE: begin
        if (start_req) begin
          if (dims_bad) begin
            state_n = ERROR;
          end else begin
            gen_load = 1'b1;
            slot_n   = '0;
            state_n  = START;
          end
        end
      end

      START: begin
        status_n = status_with(i_Status, status_bit(STATUS_START_BIT),
                               status_bit(STATUS_BUSY_BIT));
        we_n     = 1'b1;
        // An empty grid skips dispatch entirely
        state_n  = gen_remain ? DISPATCH : DONE;
      end

      DISPATCH: begin
        row_n   = gen_row;
        col_n   = gen_col;
        ready_n = NUM_PU'(1) << slot;
        state_n = WAIT_ACK;
      end

      WAIT_ACK: begin
        if (i_Indexes_Received) begin
          ready_n     = '0;
          gen_advance = 1'b1;
          state_n     = WAIT_REL;
        end
      end

      WAIT_REL: begin
        if (!i_Indexes_Received) begin
          if ((slot < SLOT_W'(NUM_PU - 1)) && gen_remain) begin
            slot_n  = slot + SLOT_W'(1);
            state_n = DISPATCH;
          end else begin
            slot_n  = '0;
            state_n = WAIT_RESULT;
          end
        end
      end

      WAIT_RESULT: begin
        if (result_rise) begin
          state_n = gen_remain ? DISPATCH : DONE;
        end
      end

      DONE: begin
        status_n = status_with(i_Status,
                               status_bit(STATUS_START_BIT) | status_bit(STATUS_BUSY_BIT),
                               status_bit(STATUS_DONE_BIT));
        we_n     = 1'b1;
        state_n  = IDLE;
      end

      ERROR: begin
        status_n = status_with(i_Status,
                               status_bit(STATUS_START_BIT) | status_bit(STATUS_BUSY_BIT),
                               status_bit(STATUS_ERROR_BIT));
        we_n     = 1'b1;
        state_n  = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_main_cu.sv
// Self-checking bench for main_cu: table of expected dispatches for a 3x3
// and a 1x2 grid, plus hand-written reset, busy-ignore and dimension cases.
module tb_main_cu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg;
  logic [31:0] status_in;
  logic        recv;
  logic        res;
  logic [31:0] status_out;
  logic        we;
  logic [3:0]  ready;
  logic [7:0]  row;
  logic [7:0]  col;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  main_cu #(.NUM_PU(4), .IDX_W(8)) dut (
    .i_Clock              (clk),
    .i_Reset              (rst),
    .i_Config             (cfg),
    .i_Status             (status_in),
    .i_Indexes_Received   (recv),
    .i_Result_Ready       (res),
    .o_Status             (status_out),
    .o_Write_Status_Enable(we),
    .o_Indexes_Ready      (ready),
    .o_Row_Index          (row),
    .o_Column_Index       (col)
  );

  typedef struct packed {
    logic [31:0] cfg;
    logic        first;
    logic [3:0]  ready;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        batch_end;
    logic        last;
  } vec_t;

  vec_t tab [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_status"}, status_out, 32'h0);
    check({tag, "_we"},     32'(we),    32'h0);
    check({tag, "_ready"},  32'(ready), 32'h0);
    check({tag, "_row"},    32'(row),   32'h0);
    check({tag, "_col"},    32'(col),   32'h0);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ready != 4'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_ready_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ready == 4'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_we(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (we) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Start request with exact busy-write timing; models the status register update
  task automatic start_op(input logic [31:0] c);
    @(negedge clk);
    cfg       = c;
    status_in = 32'h8000_0000;
    @(negedge clk);
    check("we_before_busy", 32'(we), 32'h0);
    @(negedge clk);
    check("busy_we", 32'(we), 32'h1);
    check("busy_status", status_out, 32'h4000_0000);
    status_in = 32'h4000_0000;
    @(negedge clk);
    check("busy_we_one_cycle", 32'(we), 32'h0);
  endtask

  // Watch n cycles: count writes (updating the status model), note any Ready
  task automatic observe(input int n, output int we_cnt, output logic [31:0] last_st,
                         output bit ready_seen);
    we_cnt     = 0;
    last_st    = 32'h0;
    ready_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (we) begin
        we_cnt++;
        last_st   = status_out;
        status_in = status_out;
      end
      if (ready != 4'b0) ready_seen = 1'b1;
    end
  endtask

  initial begin
    bit          ok;
    bit          seen;
    int          wcnt;
    logic [31:0] lst;

    tab[0]  = '{32'h0303_0303, 1'b1, 4'b0001, 8'd0, 8'd0, 1'b0, 1'b0};
    tab[1]  = '{32'h0303_0303, 1'b0, 4'b0010, 8'd0, 8'd1, 1'b0, 1'b0};
    tab[2]  = '{32'h0303_0303, 1'b0, 4'b0100, 8'd0, 8'd2, 1'b0, 1'b0};
    tab[3]  = '{32'h0303_0303, 1'b0, 4'b1000, 8'd1, 8'd0, 1'b1, 1'b0};
    tab[4]  = '{32'h0303_0303, 1'b0, 4'b0001, 8'd1, 8'd1, 1'b0, 1'b0};
    tab[5]  = '{32'h0303_0303, 1'b0, 4'b0010, 8'd1, 8'd2, 1'b0, 1'b0};
    tab[6]  = '{32'h0303_0303, 1'b0, 4'b0100, 8'd2, 8'd0, 1'b0, 1'b0};
    tab[7]  = '{32'h0303_0303, 1'b0, 4'b1000, 8'd2, 8'd1, 1'b1, 1'b0};
    tab[8]  = '{32'h0303_0303, 1'b0, 4'b0001, 8'd2, 8'd2, 1'b1, 1'b1};
    tab[9]  = '{32'h0102_0202, 1'b1, 4'b0001, 8'd0, 8'd0, 1'b0, 1'b0};
    tab[10] = '{32'h0102_0202, 1'b0, 4'b0010, 8'd0, 8'd1, 1'b1, 1'b1};

    rst       = 1'b1;
    cfg       = 32'h0;
    status_in = 32'h0;
    recv      = 1'b0;
    res       = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Table-driven dispatch sequences
    for (int i = 0; i < 11; i++) begin
      if (tab[i].first) begin
        start_op(tab[i].cfg);
        check("first_ready_latency", 32'(ready != 4'b0), 32'h1);
      end
      wait_ready(ok);
      check("ready_wait", 32'(ok), 32'h1);
      check($sformatf("ready[%0d]", i), 32'(ready), 32'(tab[i].ready));
      check($sformatf("row[%0d]", i),   32'(row),   32'(tab[i].row));
      check($sformatf("col[%0d]", i),   32'(col),   32'(tab[i].col));
      if (i == 0) begin
        // Result edge while waiting for ack must be ignored
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
      end
      repeat (2) @(negedge clk);
      check($sformatf("hold_ready[%0d]", i), 32'(ready), 32'(tab[i].ready));
      check($sformatf("hold_idx[%0d]", i), {16'h0, row, col}, {16'h0, tab[i].row, tab[i].col});
      recv = 1'b1;
      @(negedge clk);
      wait_ready_low(ok);
      check("ack_clears_ready", 32'(ok), 32'h1);
      recv = 1'b0;
      if (tab[i].batch_end) begin
        seen = 1'b0;
        repeat (6) begin
          @(negedge clk);
          if (ready != 4'b0) seen = 1'b1;
        end
        check($sformatf("no_ready_before_result[%0d]", i), 32'(seen), 32'h0);
        res = 1'b1;
        @(negedge clk);
        if (tab[i].last) begin
          wait_we(ok);
          check("done_we", 32'(ok), 32'h1);
          check("done_status", status_out, 32'h2000_0000);
          status_in = status_out;
          @(negedge clk);
          check("done_we_one_cycle", 32'(we), 32'h0);
          res = 1'b0;
          observe(4, wcnt, lst, seen);
          check("idle_after_done", 32'(wcnt) + 32'(seen), 32'h0);
        end else begin
          res = 1'b0;
        end
      end
    end

    // Start while busy is ignored
    @(negedge clk);
    cfg       = 32'h0303_0303;
    status_in = 32'hC000_0000;
    observe(8, wcnt, lst, seen);
    check("busy_start_ignored", 32'(wcnt) + 32'(seen), 32'h0);
    status_in = 32'h0;

`ifdef MAIN_CU_DIM_CHECK_EN
    // Mismatched inner dimension reports error without dispatch
    @(negedge clk);
    cfg       = 32'h0302_0303;
    status_in = 32'h8000_0000;
    observe(10, wcnt, lst, seen);
    check("err_writes", 32'(wcnt), 32'h1);
    check("err_status", lst, 32'h1000_0000);
    check("err_no_ready", 32'(seen), 32'h0);
`else
    // Zero-dimension grid: busy then done, no dispatch
    @(negedge clk);
    cfg       = 32'h0003_0300;
    status_in = 32'h8000_0000;
    observe(10, wcnt, lst, seen);
    check("zero_writes", 32'(wcnt), 32'h2);
    check("zero_status", lst, 32'h2000_0000);
    check("zero_no_ready", 32'(seen), 32'h0);
`endif
    status_in = 32'h0;

    // Reset in the middle of a handshake, then replay from (0,0)
    start_op(32'h0303_0303);
    wait_ready(ok);
    check("mid_ready_wait", 32'(ok), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst       = 1'b0;
    status_in = 32'h0;
    start_op(32'h0303_0303);
    check("replay_ready", 32'(ready), 32'h1);
    check("replay_idx", {16'h0, row, col}, 32'h0);

    rst = 1'b1;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
